fp_operand_sched: RTL and testbench

Front-end scheduler for the single-precision arithmetic datapath. It arbitrates round-robin between two operand-pair requesters and time-shares one `init_number` unpack instance across operand A and operand B. It registers the decomposed fields (sign, exp, mantis, ext_mantis, type) of both operands and presents them as one unpacked pair to the downstream adder/multiplier over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/init_number.sv | 37 +++
 rtl/fp_operand_sched.sv | 162 ++++++++++++++++
 tb/tb_fp_operand_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, class codes, state encoding and field bundle for the fp front end
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int EXT_W  = 26;
    localparam int TYPE_W = 3;

    localparam logic [TYPE_W-1:0] ZERO    = 3'd0;
    localparam logic [TYPE_W-1:0] SUBNORM = 3'd1;
    localparam logic [TYPE_W-1:0] NORMAL  = 3'd2;
    localparam logic [TYPE_W-1:0] INF     = 3'd3;
    localparam logic [TYPE_W-1:0] NAN     = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UNPACK_A = 2'd1,
        UNPACK_B = 2'd2,
        OUT      = 2'd3
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic [EXT_W-1:0]  ext;
        logic [TYPE_W-1:0] typ;
    } fields_t;

endpackage

// File: rtl/init_number.sv
// rtl/init_number.sv - splits one single-precision word into sign, exponent, fraction, extended mantissa and class
module init_number
    import fp_pkg::*;
(
    input  logic [31:0]       num_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o,
    output logic [EXT_W-1:0]  ext_o,
    output logic [TYPE_W-1:0] type_o
);

    logic exp_zero;
    logic exp_ones;
    logic mant_zero;

    assign sign_o    = num_i[31];
    assign exp_o     = num_i[30:23];
    assign mant_o    = num_i[22:0];
    assign exp_zero  = (num_i[30:23] == 8'h00);
    assign exp_ones  = (num_i[30:23] == 8'hFF);
    assign mant_zero = (num_i[22:0] == 23'd0);

    // Hidden bit on top, two zero guard bits below the fraction for later alignment.
    assign ext_o = {~exp_zero, num_i[22:0], 2'b00};

    // Classify from the exponent extremes and whether the fraction is empty.
    always_comb begin
        type_o = NORMAL;
        if (exp_zero) begin
            type_o = mant_zero ? ZERO : SUBNORM;
        end else if (exp_ones) begin
            type_o = mant_zero ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_operand_sched.sv
// rtl/fp_operand_sched.sv - round-robin operand-pair scheduler sharing one unpacker over A then B; FP_NAN_SKIP_EN enables NaN short-cut
module fp_operand_sched
    import fp_pkg::*;
#(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [31:0]       req0_a,
    input  logic [31:0]       req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [31:0]       req1_a,
    input  logic [31:0]       req1_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_id,
    output logic              out_sign_a,
    output logic              out_sign_b,
    output logic [EXP_W-1:0]  out_exp_a,
    output logic [EXP_W-1:0]  out_exp_b,
    output logic [MANT_W-1:0] out_mant_a,
    output logic [MANT_W-1:0] out_mant_b,
    output logic [EXT_W-1:0]  out_ext_a,
    output logic [EXT_W-1:0]  out_ext_b,
    output logic [TYPE_W-1:0] out_type_a,
`ifdef FP_NAN_SKIP_EN
    output logic [TYPE_W-1:0] out_type_b,
    output logic              out_skip
`else
    output logic [TYPE_W-1:0] out_type_b
`endif
);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [31:0] a_q, b_q;
    logic        id_q;
    fields_t     fa_q, fb_q;
    fields_t     un;
    logic [31:0] un_in;
    logic        grant_valid;
    logic        grant_id;
`ifdef FP_NAN_SKIP_EN
    logic        skip_q;
`endif

    // Priority holder wins when valid, otherwise the other valid requester.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (prio_q) begin
            grant_id = req1_valid ? 1'b1 : 1'b0;
        end else begin
            grant_id = req0_valid ? 1'b0 : 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && grant_valid && !grant_id;
    assign req1_ready = (state_q == IDLE) && grant_valid &&  grant_id;

    // The single unpacker sees B only while B is being captured.
    assign un_in = (state_q == UNPACK_B) ? b_q : a_q;

    init_number u_init_number (
        .num_i  (un_in),
        .sign_o (un.sign),
        .exp_o  (un.exp),
        .mant_o (un.mant),
        .ext_o  (un.ext),
        .type_o (un.typ)
    );

    // Next state and priority hand-over.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = UNPACK_A;
                    prio_d  = ~grant_id;
                end
            end
            UNPACK_A: begin
`ifdef FP_NAN_SKIP_EN
                state_d = (un.typ == NAN) ? OUT : UNPACK_B;
`else
                state_d = UNPACK_B;
`endif
            end
            UNPACK_B: state_d = OUT;
            OUT:      if (out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and priority registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= PRIO_INIT;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Operand latch on accept, then field capture for A and B in turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            fa_q   <= '0;
            fb_q   <= '0;
`ifdef FP_NAN_SKIP_EN
            skip_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        a_q  <= grant_id ? req1_a : req0_a;
                        b_q  <= grant_id ? req1_b : req0_b;
                        id_q <= grant_id;
                    end
                end
                UNPACK_A: begin
                    fa_q <= un;
`ifdef FP_NAN_SKIP_EN
                    skip_q <= (un.typ == NAN);
                    if (un.typ == NAN) begin
                        fb_q <= '0;
                    end
`endif
                end
                UNPACK_B: fb_q <= un;
                default: ;
            endcase
        end
    end

    assign out_valid  = (state_q == OUT);
    assign out_id     = id_q;
    assign out_sign_a = fa_q.sign;
    assign out_exp_a  = fa_q.exp;
    assign out_mant_a = fa_q.mant;
    assign out_ext_a  = fa_q.ext;
    assign out_type_a = fa_q.typ;
    assign out_sign_b = fb_q.sign;
    assign out_exp_b  = fb_q.exp;
    assign out_mant_b = fb_q.mant;
    assign out_ext_b  = fb_q.ext;
    assign out_type_b = fb_q.typ;
`ifdef FP_NAN_SKIP_EN
    assign out_skip   = skip_q;
`endif

endmodule

// File: tb/tb_fp_operand_sched.sv
// tb/tb_fp_operand_sched.sv - scoreboard bench for fp_operand_sched
module tb_fp_operand_sched;

`ifdef FP_NAN_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [25:0] x;
        logic [2:0]  t;
    } fld_t;

    typedef struct {
        logic id;
        fld_t a;
        fld_t b;
        logic skip;
        int   acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, out_ready;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        out_valid, out_id, out_sign_a, out_sign_b;
    logic [7:0]  out_exp_a, out_exp_b;
    logic [22:0] out_mant_a, out_mant_b;
    logic [25:0] out_ext_a, out_ext_b;
    logic [2:0]  out_type_a, out_type_b;
    logic        out_skip;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    logic [31:0] optab [12] = '{32'h3F800000, 32'hC0000000, 32'h00000000, 32'h80000000,
                                32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
                                32'h00000001, 32'h807FFFFF, 32'h7F7FFFFF, 32'h40490FDB};

    fp_operand_sched #(.PRIO_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_sign_a (out_sign_a),
        .out_sign_b (out_sign_b),
        .out_exp_a  (out_exp_a),
        .out_exp_b  (out_exp_b),
        .out_mant_a (out_mant_a),
        .out_mant_b (out_mant_b),
        .out_ext_a  (out_ext_a),
        .out_ext_b  (out_ext_b),
        .out_type_a (out_type_a),
`ifdef FP_NAN_SKIP_EN
        .out_type_b (out_type_b),
        .out_skip   (out_skip)
`else
        .out_type_b (out_type_b)
`endif
    );

`ifndef FP_NAN_SKIP_EN
    assign out_skip = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic fld_t model(input logic [31:0] v);
        fld_t f;
        f.s = v[31];
        f.e = v[30:23];
        f.m = v[22:0];
        case (f.e)
            8'h00:   f.t = (f.m == 23'd0) ? 3'd0 : 3'd1;
            8'hFF:   f.t = (f.m == 23'd0) ? 3'd3 : 3'd4;
            default: f.t = 3'd2;
        endcase
        f.x = {(f.e != 8'h00), f.m, 2'b00};
        return f;
    endfunction

    function automatic exp_t make_exp(input logic id, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        r.id   = id;
        r.a    = model(a);
        r.b    = model(b);
        r.skip = SKIP_EN && (r.a.t == 3'd4);
        if (r.skip) r.b = '0;
        r.acc  = cyc;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        int i;
        i = $urandom_range(0, 15);
        return (i < 12) ? optab[i] : $urandom;
    endfunction

    function automatic fld_t got_a();
        return {out_sign_a, out_exp_a, out_mant_a, out_ext_a, out_type_a};
    endfunction

    function automatic fld_t got_b();
        return {out_sign_b, out_exp_b, out_mant_b, out_ext_b, out_type_b};
    endfunction

    // Monitor: push on accept, pop and compare on output handshake, watch latency and hold.
    initial begin
        logic prev_valid;
        logic prev_stall;
        fld_t snap_a, snap_b;
        exp_t e;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        snap_a = '0;
        snap_b = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check_eq("one_grant", req0_ready & req1_ready, 0);
                if (out_valid) check_eq("ready_in_out", {req0_ready, req1_ready}, 0);
                if (out_valid && !prev_valid) begin
                    if (sb.size() == 0) check_eq("unexpected_out", 1, 0);
                    else check_eq("latency", cyc - sb[0].acc, sb[0].skip ? 2 : 3);
                end
                if (out_valid && prev_stall) begin
                    check_eq("hold_a", got_a(), snap_a);
                    check_eq("hold_b", got_b(), snap_b);
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("out_id", out_id, e.id);
                    check_eq("fields_a", got_a(), e.a);
                    check_eq("fields_b", got_b(), e.b);
                    if (SKIP_EN) check_eq("skip", out_skip, e.skip);
                end
                if (req0_valid && req0_ready) sb.push_back(make_exp(1'b0, req0_a, req0_b));
                if (req1_valid && req1_ready) sb.push_back(make_exp(1'b1, req1_a, req1_b));
                prev_valid = out_valid;
                prev_stall = out_valid && !out_ready;
                snap_a = got_a();
                snap_b = got_b();
            end
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) check_eq("valid_timeout", 0, 1);
    endtask

    task automatic wait_accept(input logic id);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        check_eq("accept_timeout", seen, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        check_eq("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   ng;
        int   gr;
        logic g [4];

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'hC0000000;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        out_ready = 1'b1;

        // Reset held with a live request.
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_id", out_id, 0);
        check_eq("rst_fields_a", got_a(), 0);
        check_eq("rst_fields_b", got_b(), 0);
        if (SKIP_EN) check_eq("rst_skip", out_skip, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_ready0", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 1'b0;

        // Single request 1.0 / -2.0.
        wait_valid(n);
        check_eq("single_lat", n, 3);
        check_eq("single_id", out_id, 0);
        check_eq("single_a", {out_sign_a, out_exp_a, out_mant_a, out_type_a}, {1'b0, 8'h7F, 23'd0, 3'd2});
        check_eq("single_b", {out_sign_b, out_exp_b, out_mant_b, out_type_b}, {1'b1, 8'h80, 23'd0, 3'd2});
        drain();

        // Arbitration from a fresh reset, both requesters valid throughout.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        req0_a = pick(); req0_b = pick(); req1_a = pick(); req1_b = pick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        ng = 0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge clk);
            gr = -1;
            if (req0_ready) gr = 0;
            else if (req1_ready) gr = 1;
            if (gr >= 0) begin
                g[ng] = gr[0];
                ng++;
            end
            @(posedge clk); #1;
            if (ng >= 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end else if (gr == 0) begin
                req0_a = pick(); req0_b = pick();
            end else if (gr == 1) begin
                req1_a = pick(); req1_b = pick();
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("arb_count", ng, 4);
        for (int i = 0; i < 4; i++) check_eq($sformatf("arb_grant%0d", i), g[i], i % 2);
        drain();

        // Backpressure: five stalled cycles in OUT with req0 waiting.
        @(posedge clk); #1 req1_valid = 1'b1; req1_a = 32'h40490FDB; req1_b = 32'hBF000000;
        wait_accept(1'b1);
        @(posedge clk); #1 req1_valid = 1'b0; out_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h00000001; req0_b = 32'hFF800000;
        wait_valid(n);
        repeat (4) begin
            @(negedge clk);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_readies", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_hs_valid", out_valid, 1);
        @(negedge clk);
        check_eq("bp_next_accept", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        drain();

        // NaN in A.
        @(posedge clk); #1 req0_valid = 1'b1; req0_a = 32'h7FC00000; req0_b = 32'h40400000;
        wait_accept(1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_valid(n);
        check_eq("nan_lat", n, SKIP_EN ? 2 : 3);
        check_eq("nan_type_a", out_type_a, 4);
        check_eq("nan_exp_b", out_exp_b, SKIP_EN ? 8'h00 : 8'h80);
        check_eq("nan_type_b", out_type_b, SKIP_EN ? 3'd0 : 3'd2);
        if (SKIP_EN) check_eq("nan_skip", out_skip, 1);
        drain();

        // Reset while in UNPACK_B; priority must return to PRIO_INIT.
        @(posedge clk); #1 req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        wait_accept(1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_type_a", out_type_a, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h40490FDB; req0_b = 32'h00000000;
        req1_a = 32'hC0000000; req1_b = 32'h3F800000;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_grant", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
